onehot_result_fifo: RTL and testbench

Result-side stage that sits directly downstream of the 16-bit one-hot quaternary adder. It accepts the adder's 32-bit one-hot result word, which holds 8 base-4 digits with 4 wires each, through a valid/ready handshake. Each word is decoded to 16-bit binary and buffered in a small FIFO, then presented to the consumer through a second valid/ready handshake. An optional checker flags result digits that are not exactly one-hot.

---
 rtl/onehot_result_fifo.sv | 114 +++++++++++
 tb/tb_onehot_result_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/onehot_result_fifo.sv
// Decodes 8-digit one-hot quaternary adder results to binary and buffers them in a small FIFO.
// Define ONEHOT_CHECK_EN to build the malformed-digit checker (out_bad / err_sticky).

module onehot_digit_dec (
    input  logic [3:0] w,
    output logic [1:0] bin
);
    // Digit value 0 contributes no set bits, so w[0] never reaches the binary result.
    logic unused_w0;
    assign unused_w0 = w[0];
    assign bin[1]    = w[2] | w[3];
    assign bin[0]    = w[1] | w[3];
endmodule

module onehot_result_fifo #(
    parameter int DEPTH  = 4,
    parameter int DIGITS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4*DIGITS-1:0]      in_res,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*DIGITS-1:0]      out_data,
    output logic                     out_bad,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_sticky,
    input  logic                     err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          push, pop;

    logic [DIGITS-1:0][1:0] dec_bin;
    logic [2*DIGITS-1:0]    data_mem [DEPTH];

    genvar d;
    generate
        for (d = 0; d < DIGITS; d++) begin : g_dec
            onehot_digit_dec u_dec (
                .w   (in_res[4*d +: 4]),
                .bin (dec_bin[d])
            );
        end
    endgenerate

    assign in_ready  = (cnt != FULL);
    assign out_valid = (cnt != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = cnt;
    assign out_data  = out_valid ? data_mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry contents survive reset; only pointers and occupancy are cleared.
    always_ff @(posedge clk) begin
        if (push) data_mem[wr_ptr] <= dec_bin;
    end

`ifdef ONEHOT_CHECK_EN
    logic [DIGITS-1:0] dig_bad;
    logic              word_bad;
    logic              bad_mem [DEPTH];

    generate
        for (d = 0; d < DIGITS; d++) begin : g_chk
            logic [3:0] w;
            assign w          = in_res[4*d +: 4];
            assign dig_bad[d] = !(w == 4'b0001 || w == 4'b0010 ||
                                  w == 4'b0100 || w == 4'b1000);
        end
    endgenerate

    assign word_bad = |dig_bad;
    assign out_bad  = out_valid & bad_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) bad_mem[wr_ptr] <= word_bad;
    end

    // A bad push in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  err_sticky <= 1'b0;
        else if (push & word_bad) err_sticky <= 1'b1;
        else if (err_clr)         err_sticky <= 1'b0;
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign out_bad        = 1'b0;
    assign err_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_result_fifo.sv
// Directed self-checking bench for onehot_result_fifo (DEPTH=4, DIGITS=8).

module tb_onehot_result_fifo;
`ifdef ONEHOT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_res = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_bad;
    logic [2:0]  count;
    logic        err_sticky;
    logic        err_clr = 1'b0;

    int tests = 0;
    int fails = 0;

    onehot_result_fifo #(.DEPTH(4), .DIGITS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_res     (in_res),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_bad    (out_bad),
        .count      (count),
        .err_sticky (err_sticky),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        tests++; if (count !== 3'd0)     begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (out_data !== 16'h0) begin fails++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
        tests++; if (out_bad !== 1'b0)   begin fails++; $display("FAIL reset_out_bad: got %b want 0", out_bad); end
        tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL reset_err_sticky: got %b want 0", err_sticky); end
        tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_decode();
        in_valid = 1'b1; in_res = 32'h12141821; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1)    begin fails++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        tests++; if (out_data !== 16'h1234) begin fails++; $display("FAIL basic_data: got %h want 1234", out_data); end
        tests++; if (out_bad !== 1'b0)      begin fails++; $display("FAIL basic_bad: got %b want 0", out_bad); end
        tests++; if (count !== 3'd1)        begin fails++; $display("FAIL basic_count1: got %0d want 1", count); end
        tick();
        tests++; if (count !== 3'd0)        begin fails++; $display("FAIL basic_count0: got %0d want 0", count); end
        tests++; if (out_data !== 16'h0)    begin fails++; $display("FAIL basic_empty_data: got %h want 0000", out_data); end
        out_ready = 1'b0;
    endtask

    task automatic test_extremes();
        out_ready = 1'b0;
        in_valid = 1'b1; in_res = 32'h11111111; tick();
        in_res = 32'h88888888; tick();
        in_valid = 1'b0;
        tests++; if (count !== 3'd2)        begin fails++; $display("FAIL ext_count: got %0d want 2", count); end
        tests++; if (out_data !== 16'h0000) begin fails++; $display("FAIL ext_first: got %h want 0000", out_data); end
        out_ready = 1'b1; tick();
        tests++; if (out_data !== 16'hFFFF) begin fails++; $display("FAIL ext_second: got %h want ffff", out_data); end
        tick();
        tests++; if (count !== 3'd0)        begin fails++; $display("FAIL ext_drain: got %0d want 0", count); end
        out_ready = 1'b0;
    endtask

    task automatic test_full_wrap();
        logic [31:0] words [5];
        logic [15:0] vals  [5];
        words[0] = 32'h11111112; vals[0] = 16'h0001;
        words[1] = 32'h11111114; vals[1] = 16'h0002;
        words[2] = 32'h11111118; vals[2] = 16'h0003;
        words[3] = 32'h11111121; vals[3] = 16'h0004;
        words[4] = 32'h11111122; vals[4] = 16'h0005;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_res = words[i]; tick();
        end
        tests++; if (count !== 3'd4)    begin fails++; $display("FAIL full_count: got %0d want 4", count); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        in_res = words[4]; tick();
        tests++; if (count !== 3'd4)    begin fails++; $display("FAIL full_held: got %0d want 4", count); end
        tests++; if (out_data !== vals[0]) begin fails++; $display("FAIL full_head: got %h want %h", out_data, vals[0]); end
        out_ready = 1'b1; tick();
        out_ready = 1'b0;
        tests++; if (count !== 3'd3)    begin fails++; $display("FAIL full_pop_count: got %0d want 3", count); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_reopen: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        tests++; if (count !== 3'd4)    begin fails++; $display("FAIL full_fifth_in: got %0d want 4", count); end
        out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            tests++; if (out_data !== vals[i]) begin fails++; $display("FAIL wrap_order%0d: got %h want %h", i, out_data, vals[i]); end
            tick();
        end
        tests++; if (count !== 3'd0)    begin fails++; $display("FAIL wrap_drain: got %0d want 0", count); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [5];
        logic [15:0] vals  [5];
        words[0] = 32'h12141821; vals[0] = 16'h1234;
        words[1] = 32'h88888888; vals[1] = 16'hFFFF;
        words[2] = 32'h11111112; vals[2] = 16'h0001;
        words[3] = 32'h11111114; vals[3] = 16'h0002;
        words[4] = 32'h11111118; vals[4] = 16'h0003;
        out_ready = 1'b0; in_valid = 1'b1;
        in_res = words[0]; tick();
        in_res = words[1]; tick();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_res = words[i+2];
            tests++; if (out_data !== vals[i]) begin fails++; $display("FAIL b2b_head%0d: got %h want %h", i, out_data, vals[i]); end
            tick();
            tests++; if (count !== 3'd2) begin fails++; $display("FAIL b2b_count%0d: got %0d want 2", i, count); end
        end
        in_valid = 1'b0;
        for (int i = 3; i < 5; i++) begin
            tests++; if (out_data !== vals[i]) begin fails++; $display("FAIL b2b_drain%0d: got %h want %h", i, out_data, vals[i]); end
            tick();
        end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_malformed();
        out_ready = 1'b0; in_valid = 1'b1;
        in_res = 32'h11111113; tick();
        in_res = 32'h11111110; tick();
        in_valid = 1'b0;
        tests++; if (out_data !== 16'h0001) begin fails++; $display("FAIL bad1_data: got %h want 0001", out_data); end
        tests++; if (out_bad !== CHK)       begin fails++; $display("FAIL bad1_flag: got %b want %b", out_bad, CHK); end
        tests++; if (err_sticky !== CHK)    begin fails++; $display("FAIL bad_sticky: got %b want %b", err_sticky, CHK); end
        out_ready = 1'b1; tick();
        tests++; if (out_data !== 16'h0000) begin fails++; $display("FAIL bad2_data: got %h want 0000", out_data); end
        tests++; if (out_bad !== CHK)       begin fails++; $display("FAIL bad2_flag: got %b want %b", out_bad, CHK); end
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1; in_res = 32'h11111110; err_clr = 1'b1; tick();
        in_valid = 1'b0;
        tests++; if (err_sticky !== CHK)    begin fails++; $display("FAIL clr_vs_set: got %b want %b", err_sticky, CHK); end
        tick();
        err_clr = 1'b0;
        tests++; if (err_sticky !== 1'b0)   begin fails++; $display("FAIL clr_alone: got %b want 0", err_sticky); end
        out_ready = 1'b1; tick();
        out_ready = 1'b0;
        tests++; if (count !== 3'd0)        begin fails++; $display("FAIL bad_drain: got %0d want 0", count); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1;
        in_res = 32'h11111112; tick();
        in_res = 32'h11111114; tick();
        in_res = 32'h11111118; tick();
        in_valid = 1'b0;
        tests++; if (count !== 3'd3)     begin fails++; $display("FAIL mid_count3: got %0d want 3", count); end
        rst = 1'b1; #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        tests++; if (count !== 3'd0)     begin fails++; $display("FAIL mid_count0: got %0d want 0", count); end
        tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
        tick();
        rst = 1'b0;
        in_valid = 1'b1; in_res = 32'h12141821; out_ready = 1'b1; tick();
        in_valid = 1'b0;
        tests++; if (out_data !== 16'h1234) begin fails++; $display("FAIL mid_fresh: got %h want 1234", out_data); end
        tick();
        tests++; if (count !== 3'd0)     begin fails++; $display("FAIL mid_drain: got %0d want 0", count); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_decode();
        test_extremes();
        test_full_wrap();
        test_back_to_back();
        test_malformed();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
